// File: rtl/turn_timer.sv
// turn_timer: per-turn countdown for the game controller.
// Counts down on tick while the game FSM is in PLAY. Works either as a
// per-move clock (reload on every turn change) or as a per-player time bank.
// Reports remaining time, a low-time warning and a one-cycle timeout pulse.
module turn_timer #(
  parameter int CNT_W       = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int TURN_W      = $clog2(NUM_PLAYERS),
  parameter int BANK_MODE   = 0,
  parameter int WARN_TH     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [2:0]        state,
  input  logic [TURN_W-1:0] turn,
  input  logic [CNT_W-1:0]  init_time,
  input  logic              pause,
  output logic [CNT_W-1:0]  count,
  output logic              running,
  output logic              warn,
  output logic              timeout,
  output logic [TURN_W-1:0] timeout_player
);

  localparam logic [2:0]  PLAY   = 3'b001;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_EXP  = 2'd2;
  localparam logic [31:0] WTH    = 32'(WARN_TH);
  localparam logic [31:0] NP     = 32'(NUM_PLAYERS);

  logic [1:0]                        fsm, fsm_nxt;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0] bank, bank_nxt;
  logic [CNT_W-1:0]                  cnt_nxt, sel_cnt;
  logic [TURN_W-1:0]                 turn_q, tp_nxt;
  logic                              to_nxt;
  logic                              play, turn_chg, turn_ok;

  assign play     = (state == PLAY);
  assign turn_chg = (turn != turn_q);
  // Out-of-range turn indices freeze every counter.
  assign turn_ok  = (32'(turn) < NP);
  // Value the active counter takes on a turn change; bank[turn] is only
  // consumed when turn_ok is set.
  assign sel_cnt  = (BANK_MODE != 0) ? bank[turn] : init_time;

  // Next-state decode: IDLE / RUN / EXPIRED with abort > turn change > tick.
  always_comb begin
    fsm_nxt  = fsm;
    cnt_nxt  = count;
    bank_nxt = bank;
    to_nxt   = 1'b0;
    tp_nxt   = timeout_player;
    case (fsm)
      S_IDLE: begin
        cnt_nxt = init_time;
        for (int i = 0; i < NUM_PLAYERS; i++) bank_nxt[i] = init_time;
        if (play) fsm_nxt = S_RUN;
      end
      S_RUN: begin
        if (!play) begin
          fsm_nxt = S_IDLE;
          cnt_nxt = init_time;
          for (int i = 0; i < NUM_PLAYERS; i++) bank_nxt[i] = init_time;
        end else if (turn_chg) begin
          if (turn_ok) cnt_nxt = sel_cnt;
        end else if (tick && !pause && turn_ok) begin
          // count mirrors bank[turn] here, so it is the active counter.
          if (count <= CNT_W'(1)) begin
            cnt_nxt        = '0;
            bank_nxt[turn] = '0;
            to_nxt         = 1'b1;
            tp_nxt         = turn;
            fsm_nxt        = S_EXP;
          end else begin
            cnt_nxt        = count - CNT_W'(1);
            bank_nxt[turn] = count - CNT_W'(1);
          end
        end
      end
      S_EXP: begin
        if (!play) begin
          fsm_nxt = S_IDLE;
          cnt_nxt = init_time;
          for (int i = 0; i < NUM_PLAYERS; i++) bank_nxt[i] = init_time;
        end else if (turn_chg) begin
          fsm_nxt = S_RUN;
          if (turn_ok) cnt_nxt = sel_cnt;
        end
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  // State and output registers; running/warn are decoded from next state so
  // they line up with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm            <= S_IDLE;
      count          <= '0;
      bank           <= '0;
      turn_q         <= '0;
      timeout        <= 1'b0;
      timeout_player <= '0;
      running        <= 1'b0;
      warn           <= 1'b0;
    end else begin
      fsm            <= fsm_nxt;
      count          <= cnt_nxt;
      bank           <= bank_nxt;
      turn_q         <= turn;
      timeout        <= to_nxt;
      timeout_player <= tp_nxt;
      running        <= (fsm_nxt == S_RUN) && !pause;
      warn           <= (fsm_nxt == S_RUN) && (32'(cnt_nxt) <= WTH);
    end
  end

endmodule
